// File: rtl/cache_ctrl_if.sv
// ============================================================================
// Module      : cache_ctrl_if
// Description : CPU-side and backing-memory-side bus bundle for cache_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cache_ctrl_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);

  logic                     cpu_req;
  logic                     cpu_we;
  logic [ADDRESS_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0]    cpu_wdata;
  logic [DATA_WIDTH-1:0]    cpu_rdata;
  logic                     stall;

  logic                     mem_req;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;
  logic                     mem_ack;

  // Cache controller view
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  // Environment view: CPU driver plus backing memory
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/cache_ctrl.sv
// ============================================================================
// Module      : cache_ctrl
// Description : Direct-mapped, one-word-per-line, write-through /
//               no-write-allocate cache controller with 0-cycle read hits.
//               Optional hit/miss counters: define CACHE_CTRL_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int SETS          = 8
) (
  input  logic         clk,
  input  logic         rst,
  cache_ctrl_if.slave  bus
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  localparam int c_IDX_W = $clog2(SETS);
  localparam int c_TAG_W = ADDRESS_WIDTH - c_IDX_W - 2;

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_RD_MISS = 2'd1;
  localparam logic [1:0] c_FILL    = 2'd2;
  localparam logic [1:0] c_WR_THRU = 2'd3;

  logic [1:0]               r_state;
  logic [SETS-1:0]          r_valid;
  logic [c_TAG_W-1:0]       r_tag  [SETS];
  logic [DATA_WIDTH-1:0]    r_data [SETS];
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;

  logic [c_IDX_W-1:0]       w_idx;
  logic [c_TAG_W-1:0]       w_tag;
  logic                     w_hit;
  logic [c_IDX_W-1:0]       w_lidx;
  logic [c_TAG_W-1:0]       w_ltag;
  logic                     w_lhit;
  logic                     w_stall;
  logic [DATA_WIDTH-1:0]    w_rdata;
  logic                     w_unused_ok;

  // Byte offset within a word never selects anything
  assign w_unused_ok = ^bus.cpu_addr[1:0];

  assign w_idx  = bus.cpu_addr[c_IDX_W+1:2];
  assign w_tag  = bus.cpu_addr[ADDRESS_WIDTH-1:c_IDX_W+2];
  assign w_hit  = r_valid[w_idx] & (r_tag[w_idx] == w_tag);

  // Lookup on the latched address, used while the memory access is in flight
  assign w_lidx = r_addr[c_IDX_W+1:2];
  assign w_ltag = r_addr[ADDRESS_WIDTH-1:c_IDX_W+2];
  assign w_lhit = r_valid[w_lidx] & (r_tag[w_lidx] == w_ltag);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_valid <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.cpu_req) begin
            if (bus.cpu_we) begin
              r_addr  <= {bus.cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
              r_wdata <= bus.cpu_wdata;
              r_state <= c_WR_THRU;
            end else if (!w_hit) begin
              r_addr  <= {bus.cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
              r_state <= c_RD_MISS;
            end
          end
        end
        c_RD_MISS: begin
          if (bus.mem_ack) begin
            r_valid[w_lidx] <= 1'b1;
            r_state         <= c_FILL;
          end
        end
        c_FILL: begin
          r_state <= c_IDLE;
        end
        c_WR_THRU: begin
          if (bus.mem_ack) begin
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Tag/data storage carries no reset; validity alone qualifies it
  always_ff @(posedge clk) begin
    if (!rst && bus.mem_ack) begin
      if (r_state == c_RD_MISS) begin
        r_tag[w_lidx]  <= w_ltag;
        r_data[w_lidx] <= bus.mem_rdata;
      end else if (r_state == c_WR_THRU && w_lhit) begin
        r_data[w_lidx] <= r_wdata;
      end
    end
  end

  always_comb begin
    w_stall = 1'b0;
    w_rdata = '0;
    case (r_state)
      c_IDLE: begin
        w_stall = bus.cpu_req & (bus.cpu_we | ~w_hit);
        if (bus.cpu_req && !bus.cpu_we && w_hit) begin
          w_rdata = r_data[w_idx];
        end
      end
      c_RD_MISS: begin
        w_stall = 1'b1;
      end
      c_FILL: begin
        w_rdata = r_data[w_lidx];
      end
      c_WR_THRU: begin
        w_stall = ~bus.mem_ack;
      end
      default: begin
        w_stall = 1'b0;
      end
    endcase
  end

  assign bus.stall     = w_stall;
  assign bus.cpu_rdata = w_rdata;
  assign bus.mem_req   = (r_state == c_RD_MISS) | (r_state == c_WR_THRU);
  assign bus.mem_we    = (r_state == c_WR_THRU);
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  // Every access is classified once, on the IDLE cycle that accepts it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (r_state == c_IDLE && bus.cpu_req) begin
      if (w_hit) begin
        if (r_hit_count != 16'hFFFF) begin
          r_hit_count <= r_hit_count + 16'd1;
        end
      end else begin
        if (r_miss_count != 16'hFFFF) begin
          r_miss_count <= r_miss_count + 16'd1;
        end
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_ctrl.sv
// ============================================================================
// Module      : tb_cache_ctrl
// Description : Scoreboard bench for cache_ctrl: directed CPU accesses, a
//               backing-memory model with programmable ack delay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int SETS = 8;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_txn_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cache_ctrl_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  cache_ctrl #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .SETS         (SETS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_rd_q[$];
  mem_txn_t    exp_mem_q[$];
  logic [31:0] tb_mem [0:255];
  bit          mem_auto  = 1'b1;
  int          ack_delay = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Backing memory: acks ack_delay cycles after it first sees mem_req
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_auto) begin
        if (bus.mem_ack) begin
          bus.mem_ack = 1'b0;
          cnt = 0;
        end else if (bus.mem_req) begin
          if (cnt >= ack_delay) begin
            bus.mem_ack = 1'b1;
            if (bus.mem_we) tb_mem[bus.mem_addr[9:2]] = bus.mem_wdata;
            else            bus.mem_rdata = tb_mem[bus.mem_addr[9:2]];
          end else begin
            cnt++;
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  // Monitor: completed loads and completed memory transactions
  always @(negedge clk) begin
    mem_txn_t t;
    if (!rst && bus.cpu_req && !bus.cpu_we && !bus.stall) begin
      if (exp_rd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_load: cpu_rdata %h, required no completed load", bus.cpu_rdata);
      end else begin
        check("cpu_rdata", bus.cpu_rdata, exp_rd_q.pop_front());
      end
    end
    if (!rst && bus.mem_req && bus.mem_ack) begin
      if (exp_mem_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_mem: we=%b addr=%h, required no memory access", bus.mem_we, bus.mem_addr);
      end else begin
        t = exp_mem_q.pop_front();
        check("mem_we", {31'd0, bus.mem_we}, {31'd0, t.we});
        check("mem_addr", bus.mem_addr, t.addr);
        if (t.we) check("mem_wdata", bus.mem_wdata, t.data);
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd_exp, input int exp_stall, input bit exp_mem);
    int stalls;
    stalls = 0;
    if (exp_mem) exp_mem_q.push_back('{we, {addr[31:2], 2'b00}, wdata});
    if (!we) exp_rd_q.push_back(rd_exp);
    @(posedge clk);
    #1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    forever begin
      @(negedge clk);
      if (!bus.stall) break;
      stalls++;
      if (stalls > 50) break;
    end
    check("stall_cycles", stalls, exp_stall);
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 32'h1000_0000 + i;
    tb_mem[8'h10] = 32'hDEADBEEF;   // 0x40
    tb_mem[8'h08] = 32'hAAAA0020;   // 0x20
    tb_mem[8'h41] = 32'h01045A5A;   // 0x104

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_stall",     {31'd0, bus.stall},   32'd0);
    check("rst_mem_req",   {31'd0, bus.mem_req}, 32'd0);
    check("rst_mem_we",    {31'd0, bus.mem_we},  32'd0);
    check("rst_mem_addr",  bus.mem_addr,         32'd0);
    check("rst_mem_wdata", bus.mem_wdata,        32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata,        32'd0);

    // Read miss/fill, read hit, store hit, store miss (no allocate)
    access(1'b0, 32'h40, 32'h0,        32'hDEADBEEF, 3, 1'b1);
    access(1'b0, 32'h40, 32'h0,        32'hDEADBEEF, 0, 1'b0);
    access(1'b1, 32'h40, 32'h12345678, 32'h0,        2, 1'b1);
    access(1'b0, 32'h40, 32'h0,        32'h12345678, 0, 1'b0);
    access(1'b1, 32'h60, 32'hCAFEF00D, 32'h0,        2, 1'b1);
    access(1'b0, 32'h60, 32'h0,        32'hCAFEF00D, 3, 1'b1);

    // Conflict on index 0: 0x20 and 0x20 + SETS*4 evict each other
    access(1'b0, 32'h20, 32'h0, 32'hAAAA0020, 3, 1'b1);
    access(1'b0, 32'h20 + SETS * 4, 32'h0, 32'h12345678, 3, 1'b1);
    access(1'b0, 32'h20, 32'h0, 32'hAAAA0020, 3, 1'b1);

    // Slower memory, a different set, and ignored byte-offset bits
    ack_delay = 3;
    access(1'b0, 32'h104, 32'h0,        32'h01045A5A, 5, 1'b1);
    access(1'b1, 32'h104, 32'h0BADF00D, 32'h0,        4, 1'b1);
    access(1'b0, 32'h104, 32'h0,        32'h0BADF00D, 0, 1'b0);
    access(1'b0, 32'h107, 32'h0,        32'h0BADF00D, 0, 1'b0);

    // Stray ack while idle must not disturb anything
    mem_auto = 1'b0;
    @(posedge clk);
    #1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    mem_auto    = 1'b1;
    access(1'b0, 32'h104, 32'h0, 32'h0BADF00D, 0, 1'b0);

    // Reset in RD_MISS, then a late ack
    ack_delay = 1;
    mem_auto  = 1'b0;
    @(posedge clk);
    #1;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h40;
    @(negedge clk);
    check("rdmiss_stall", {31'd0, bus.stall}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rdmiss_mem_req",  {31'd0, bus.mem_req}, 32'd1);
    check("rdmiss_mem_addr", bus.mem_addr,         32'h40);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    bus.cpu_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("abort_stall",   {31'd0, bus.stall},   32'd0);
    @(posedge clk);
    #1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBADBAD00;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_mem_req", {31'd0, bus.mem_req}, 32'd0);
    mem_auto = 1'b1;
    access(1'b0, 32'h40,  32'h0, 32'h12345678, 3, 1'b1);
    access(1'b0, 32'h104, 32'h0, 32'h0BADF00D, 3, 1'b1);
    access(1'b0, 32'h40,  32'h0, 32'h12345678, 0, 1'b0);

    repeat (4) @(posedge clk);
    check("rd_queue_drained",  exp_rd_q.size(),  32'd0);
    check("mem_queue_drained", exp_mem_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
